// File: rtl/div_clk_monitor.sv
// Monitors a divided clock that is sampled as data in the clk domain. It measures the
// period and high time, compares each period against an expected value and reports lock and sticky errors.
module div_clk_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 3,
    parameter int PERIOD_TOL  = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             div_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_period,
    output logic             err_stuck
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] EXP_CNT     = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_CNT     = CNT_W'(PERIOD_TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Tap 0 is the raw input; each generated stage adds one flop of delay.
    logic [SYNC_STAGES:0] sync_tap;
    assign sync_tap[0] = div_in;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= sync_tap[gi];
                end
            end
            assign sync_tap[gi+1] = stage_reg;
        end
    endgenerate

    logic             s;
    logic             s_d_reg;
    logic             rise;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [CNT_W-1:0] hc_reg, hc_next, hc_inc;
    logic [CNT_W-1:0] diff;
    logic [RUN_W-1:0] good_run_reg, good_run_next, run_inc;
    logic [CNT_W-1:0] period_reg, high_cnt_reg;
    logic             meas_valid_reg, meas_valid_next;
    logic             locked_reg, locked_next;
    logic             err_period_reg, err_period_next;
    logic             err_stuck_reg, err_stuck_next;
    logic             capture;
    logic             period_set, stuck_set;
    logic             good;
    logic             timeout;
    logic             measuring;

    assign s         = sync_tap[SYNC_STAGES];
    assign rise      = s & ~s_d_reg;
    assign cnt_inc   = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign hc_inc    = (s && !(&hc_reg)) ? hc_reg + CNT_W'(1) : hc_reg;
    assign run_inc   = (good_run_reg >= RUN_MAX) ? RUN_MAX : good_run_reg + RUN_W'(1);
    assign diff      = (cnt_reg >= EXP_CNT) ? (cnt_reg - EXP_CNT) : (EXP_CNT - cnt_reg);
    assign good      = (diff <= TOL_CNT);
    assign measuring = (state_reg == MEASURE) || (state_reg == LOCKED);
    assign timeout   = measuring && !rise && (cnt_reg == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise && good && (run_inc >= RUN_MAX)) begin
                        state_next = LOCKED;
                    end else if (timeout) begin
                        state_next = WAIT_EDGE;
                    end
                end
                LOCKED: begin
                    if (rise && !good) begin
                        state_next = MEASURE;
                    end else if (timeout) begin
                        state_next = WAIT_EDGE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Produces next values for the counters and registered outputs. A disabled monitor
    // discards any partial measurement, but it leaves the sticky errors unchanged.
    always_comb begin
        cnt_next        = cnt_reg;
        hc_next         = hc_reg;
        good_run_next   = good_run_reg;
        capture         = 1'b0;
        meas_valid_next = 1'b0;
        period_set      = 1'b0;
        stuck_set       = 1'b0;
        if (!en || (state_reg == IDLE)) begin
            cnt_next      = '0;
            hc_next       = '0;
            good_run_next = '0;
        end else if (state_reg == WAIT_EDGE) begin
            good_run_next = '0;
            if (rise) begin
                cnt_next = CNT_W'(1);
                hc_next  = CNT_W'(1);
            end else begin
                cnt_next = '0;
                hc_next  = '0;
            end
        end else if (rise) begin
            capture         = 1'b1;
            meas_valid_next = 1'b1;
            cnt_next        = CNT_W'(1);
            hc_next         = CNT_W'(1);
            if (good) begin
                good_run_next = run_inc;
            end else begin
                good_run_next = '0;
                period_set    = 1'b1;
            end
        end else if (timeout) begin
            stuck_set     = 1'b1;
            good_run_next = '0;
            cnt_next      = '0;
            hc_next       = '0;
        end else begin
            cnt_next = cnt_inc;
            hc_next  = hc_inc;
        end
        locked_next     = (state_next == LOCKED);
        err_period_next = period_set | (err_period_reg & ~clr_err);
        err_stuck_next  = stuck_set | (err_stuck_reg & ~clr_err);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_d_reg        <= 1'b0;
            cnt_reg        <= '0;
            hc_reg         <= '0;
            good_run_reg   <= '0;
            period_reg     <= '0;
            high_cnt_reg   <= '0;
            meas_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            err_period_reg <= 1'b0;
            err_stuck_reg  <= 1'b0;
        end else begin
            s_d_reg        <= s;
            cnt_reg        <= cnt_next;
            hc_reg         <= hc_next;
            good_run_reg   <= good_run_next;
            meas_valid_reg <= meas_valid_next;
            locked_reg     <= locked_next;
            err_period_reg <= err_period_next;
            err_stuck_reg  <= err_stuck_next;
            if (capture) begin
                period_reg   <= cnt_reg;
                high_cnt_reg <= hc_reg;
            end
        end
    end

    assign period     = period_reg;
    assign high_cnt   = high_cnt_reg;
    assign meas_valid = meas_valid_reg;
    assign locked     = locked_reg;
    assign err_period = err_period_reg;
    assign err_stuck  = err_stuck_reg;

endmodule
